step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter CODEWID, default 2, SHALL set the width of the step code.
REQ-002 Parameter IRWID, default 9, SHALL set the width of the instruction word; the opcode SHALL be IR[IRWID-1:IRWID-3].
REQ-003 Clock  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 Resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Run  input  1  SHALL be the start request, sampled in IDLE only.
REQ-006 DIN  input  IRWID  SHALL be the instruction word, captured when Run is accepted.
REQ-007 Hold  input  1  SHALL be the stall; it freezes step advance.
REQ-008 Clear  input  1  SHALL be the synchronous abort.
REQ-009 W  output  CODEWID  SHALL be the current step code, driven to the downstream 2-to-4 step decoder.
REQ-010 En  output  1  SHALL be the step decoder enable.
REQ-011 IR  output  IRWID  SHALL be the latched instruction.
REQ-012 Busy  output  1  SHALL be high while in EXEC.
REQ-013 Done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and EXEC.
REQ-015 W and En SHALL be driven from registers only, with no combinational path from any input.
- W = step counter.
- En = Busy = (state == EXEC).
REQ-016 The last step SHALL be set by the latched opcode:
- 000 (mv) and 001 (mvi): last step 1.
- 010 (add) and 011 (sub): last step 3.
- 100-111 (nop): last step 0.
REQ-017 In IDLE with Run=1, Hold=0 and Clear=0, the next edge SHALL:
- load IR <= DIN;
- set the counter to 0;
- enter EXEC, so En=1 and W=0 in the following cycle (1-cycle latency).
REQ-018 In IDLE with Hold=1, Run SHALL be ignored and all registers SHALL be held.
REQ-019 In EXEC with Hold=0 and the counter below the last step, the counter SHALL increment by 1 each edge.
REQ-020 In EXEC with Hold=0 and the counter equal to the last step, the next edge SHALL:
- enter IDLE;
- set the counter to 0;
- assert Done for exactly one cycle.
REQ-021 In EXEC with Hold=1, the state, counter and IR SHALL be frozen, and En SHALL stay 1.
REQ-022 Clear=1 SHALL take priority over Hold and Run, and the next edge SHALL:
- enter IDLE;
- set the counter to 0;
- leave Done at 0;
- leave IR unchanged.
REQ-023 Run and DIN SHALL be ignored while in EXEC; a pending Run SHALL NOT be queued.
REQ-024 Run=1 in the cycle where Done=1 (state IDLE) SHALL be accepted, giving back-to-back instructions with exactly one En=0 cycle between them.
REQ-025 The counter SHALL never exceed the last step and SHALL never wrap within an instruction.
REQ-026 Done and En SHALL never be high in the same cycle.
REQ-027 IR SHALL be updated only on an accepted Run.

Reset
REQ-028 Resetn=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- W=0, En=0, Busy=0, Done=0, IR=0.
REQ-029 Reset asserted mid-instruction SHALL abort it with no Done pulse.
REQ-030 After Resetn deasserts, the first accepted Run SHALL start an instruction exactly as in REQ-017.
REQ-031 All outputs SHALL be defined (no X) from the assertion of reset onward.

Verification
REQ-032 Run=1 with DIN=9'b010_000_001 (add) for one cycle -> En=1 for 4 cycles with W=0,1,2,3; Done=1 in the next cycle; Busy=1 for 4 cycles.
REQ-033 Run with DIN=9'b001_000_000 (mvi) -> W=0,1, then Done; Run with DIN=9'b111_000_000 (nop) -> W=0 for one cycle, then Done.
REQ-034 add instruction with Hold=1 for 3 cycles while W=2 -> W stays 2 and En stays 1 for those cycles, then W=3, then Done; total 7 cycles with En=1.
REQ-035 Clear=1 while W=1 of a sub instruction -> next cycle En=0, W=0, Done never asserts; IR still holds the sub opcode.
REQ-036 Resetn pulsed low between clock edges during W=2 -> W=0, En=0, IR=0 immediately; no Done pulse; a subsequent Run starts cleanly.
REQ-037 mv instruction, then Run held high continuously with a second instruction on DIN -> second instruction starts the cycle after Done, and Run pulses during EXEC change neither IR nor W.

Source files
------------

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//   Two-state (IDLE/EXEC) control sequencer for a simple multi-cycle
//   processor datapath. It latches an instruction on an accepted Run and
//   steps a counter from 0 up to a last step chosen by the opcode. The
//   counter drives a downstream 2-to-4 step decoder.
//
// Parameters
//   CODEWID : width of the step code W
//   IRWID   : width of the instruction word; opcode = IR[IRWID-1:IRWID-3]
//
// Ports
//   Clock  : in  - single clock, rising edge
//   Resetn : in  - asynchronous active-low reset
//   Run    : in  - start request, sampled in IDLE only
//   DIN    : in  - instruction word, captured when Run is accepted
//   Hold   : in  - stall, freezes all step advance
//   Clear  : in  - synchronous abort, highest priority after reset
//   W      : out - current step code (registered)
//   En     : out - step decoder enable, high while in EXEC
//   IR     : out - latched instruction
//   Busy   : out - high while in EXEC
//   Done   : out - one-cycle completion pulse
// ---------------------------------------------------------------------------
module step_sequencer #(
   parameter int CODEWID = 2,
   parameter int IRWID   = 9
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               Run,
   input  logic [IRWID-1:0]   DIN,
   input  logic               Hold,
   input  logic               Clear,
   output logic [CODEWID-1:0] W,
   output logic               En,
   output logic [IRWID-1:0]   IR,
   output logic               Busy,
   output logic               Done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t               state;
   logic [CODEWID-1:0]   cnt;
   logic [IRWID-1:0]     ir_q;
   logic                 done_q;
   logic [CODEWID-1:0]   last_step;

   // Last step is decoded from the latched opcode, never from DIN.
   always_comb begin
      last_step = '0;
      case (ir_q[IRWID-1:IRWID-3])
         3'b000, 3'b001: last_step = CODEWID'(1);   // mv, mvi
         3'b010, 3'b011: last_step = CODEWID'(3);   // add, sub
         default:        last_step = '0;            // nop
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state  <= IDLE;
         cnt    <= '0;
         ir_q   <= '0;
         done_q <= 1'b0;
      end else begin
         // Done is a pulse: it falls on every edge unless re-set below.
         done_q <= 1'b0;
         if (Clear) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (Run && !Hold) begin
                     ir_q  <= DIN;
                     cnt   <= '0;
                     state <= EXEC;
                  end
               end
               EXEC: begin
                  if (!Hold) begin
                     if (cnt == last_step) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        done_q <= 1'b1;
                     end else begin
                        cnt <= cnt + CODEWID'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   // All outputs come straight from flops; no input reaches them combinationally.
   assign W    = cnt;
   assign En   = (state == EXEC);
   assign Busy = (state == EXEC);
   assign IR   = ir_q;
   assign Done = done_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

   localparam logic [8:0] I_MV  = 9'b000_000_101;
   localparam logic [8:0] I_MVI = 9'b001_000_000;
   localparam logic [8:0] I_ADD = 9'b010_000_001;
   localparam logic [8:0] I_SUB = 9'b011_000_000;
   localparam logic [8:0] I_NOP = 9'b111_000_000;

   logic       Clock;
   logic       Resetn;
   logic       Run;
   logic [8:0] DIN;
   logic       Hold;
   logic       Clear;
   logic [1:0] W;
   logic       En;
   logic [8:0] IR;
   logic       Busy;
   logic       Done;

   typedef struct {
      logic [1:0] w;
      logic       en;
      logic       done;
      logic [8:0] ir;
   } exp_t;

   exp_t sb[$];
   int unsigned total;
   int unsigned bad;

   step_sequencer #(.CODEWID(2), .IRWID(9)) dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .Run   (Run),
      .DIN   (DIN),
      .Hold  (Hold),
      .Clear (Clear),
      .W     (W),
      .En    (En),
      .IR    (IR),
      .Busy  (Busy),
      .Done  (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge,
   // then compare them 1 time unit after that edge.
   task automatic cyc(input logic r, input logic [8:0] d, input logic h, input logic c,
                      input logic [1:0] ew, input logic een, input logic edone,
                      input logic [8:0] eir);
      exp_t e;
      Run   = r;
      DIN   = d;
      Hold  = h;
      Clear = c;
      sb.push_back('{w: ew, en: een, done: edone, ir: eir});
      @(posedge Clock);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("W",    32'(W),    32'(e.w));
         check("En",   32'(En),   32'(e.en));
         check("Busy", 32'(Busy), 32'(e.en));
         check("Done", 32'(Done), 32'(e.done));
         check("IR",   32'(IR),   32'(e.ir));
         check("done_en_excl", 32'(Done & En), 32'd0);
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      Resetn = 1'b0;
      Run    = 1'b0;
      DIN    = '0;
      Hold   = 1'b0;
      Clear  = 1'b0;

      // reset state, before any clock edge
      #3;
      check("rst_W",    32'(W),    32'd0);
      check("rst_En",   32'(En),   32'd0);
      check("rst_Busy", 32'(Busy), 32'd0);
      check("rst_Done", 32'(Done), 32'd0);
      check("rst_IR",   32'(IR),   32'd0);
      @(posedge Clock);
      #1;
      Resetn = 1'b1;

      // add: W 0..3 with En, then Done
      cyc(1, I_ADD, 0, 0, 2'd0, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd1, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd2, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd3, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd0, 0, 1, I_ADD);
      cyc(0, '0,    0, 0, 2'd0, 0, 0, I_ADD);

      // mvi, then nop accepted in the Done cycle
      cyc(1, I_MVI, 0, 0, 2'd0, 1, 0, I_MVI);
      cyc(0, '0,    0, 0, 2'd1, 1, 0, I_MVI);
      cyc(0, '0,    0, 0, 2'd0, 0, 1, I_MVI);
      cyc(1, I_NOP, 0, 0, 2'd0, 1, 0, I_NOP);
      cyc(0, '0,    0, 0, 2'd0, 0, 1, I_NOP);
      cyc(0, '0,    0, 0, 2'd0, 0, 0, I_NOP);

      // Hold in IDLE blocks Run and leaves IR alone
      cyc(1, I_ADD, 1, 0, 2'd0, 0, 0, I_NOP);
      cyc(0, '0,    0, 0, 2'd0, 0, 0, I_NOP);

      // add with a 3-cycle Hold at W=2: 7 En cycles total
      cyc(1, I_ADD, 0, 0, 2'd0, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd1, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd2, 1, 0, I_ADD);
      cyc(0, '0,    1, 0, 2'd2, 1, 0, I_ADD);
      cyc(0, '0,    1, 0, 2'd2, 1, 0, I_ADD);
      cyc(0, '0,    1, 0, 2'd2, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd3, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd0, 0, 1, I_ADD);
      cyc(0, '0,    0, 0, 2'd0, 0, 0, I_ADD);

      // sub aborted by Clear at W=1: no Done, IR keeps sub
      cyc(1, I_SUB, 0, 0, 2'd0, 1, 0, I_SUB);
      cyc(0, '0,    0, 0, 2'd1, 1, 0, I_SUB);
      cyc(0, '0,    1, 1, 2'd0, 0, 0, I_SUB);
      cyc(0, '0,    0, 0, 2'd0, 0, 0, I_SUB);
      // Clear beats Run in IDLE
      cyc(1, I_ADD, 0, 1, 2'd0, 0, 0, I_SUB);
      // Clear on the last step suppresses Done
      cyc(1, I_MV,  0, 0, 2'd0, 1, 0, I_MV);
      cyc(0, '0,    0, 0, 2'd1, 1, 0, I_MV);
      cyc(0, '0,    0, 1, 2'd0, 0, 0, I_MV);
      cyc(0, '0,    0, 0, 2'd0, 0, 0, I_MV);

      // asynchronous reset mid-instruction at W=2
      cyc(1, I_ADD, 0, 0, 2'd0, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd1, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd2, 1, 0, I_ADD);
      #2;
      Resetn = 1'b0;
      #1;
      check("arst_W",    32'(W),    32'd0);
      check("arst_En",   32'(En),   32'd0);
      check("arst_Busy", 32'(Busy), 32'd0);
      check("arst_Done", 32'(Done), 32'd0);
      check("arst_IR",   32'(IR),   32'd0);
      @(posedge Clock);
      #1;
      check("arst_hold_Done", 32'(Done), 32'd0);
      check("arst_hold_W",    32'(W),    32'd0);
      Resetn = 1'b1;
      cyc(0, '0,    0, 0, 2'd0, 0, 0, 9'd0);
      cyc(1, I_MVI, 0, 0, 2'd0, 1, 0, I_MVI);
      cyc(0, '0,    0, 0, 2'd1, 1, 0, I_MVI);
      cyc(0, '0,    0, 0, 2'd0, 0, 1, I_MVI);

      // mv, then Run held high with a second instruction on DIN
      cyc(1, I_MV,  0, 0, 2'd0, 1, 0, I_MV);
      cyc(1, I_ADD, 0, 0, 2'd1, 1, 0, I_MV);
      cyc(1, I_ADD, 0, 0, 2'd0, 0, 1, I_MV);
      cyc(1, I_ADD, 0, 0, 2'd0, 1, 0, I_ADD);
      cyc(1, I_SUB, 0, 0, 2'd1, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd2, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd3, 1, 0, I_ADD);
      cyc(0, '0,    0, 0, 2'd0, 0, 1, I_ADD);
      cyc(0, '0,    0, 0, 2'd0, 0, 0, I_ADD);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
